// File: rtl/lut_ram_arbiter.sv
// Arbiter sharing a dual-port LUT RAM (port0 read-only, port1 read/write) between two
// readers and one writer. Define LUT_ARB_INIT_EN to sweep INIT_VAL into every entry after reset.
module lut_ram_arbiter #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 9,
  parameter int                MEM_SIZE = 512,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdA_req,
  input  logic [AWIDTH-1:0] rdA_addr,
  output logic              rdA_gnt,
  output logic              rdA_vld,
  output logic [DWIDTH-1:0] rdA_data,
  input  logic              rdB_req,
  input  logic [AWIDTH-1:0] rdB_addr,
  output logic              rdB_gnt,
  output logic              rdB_vld,
  output logic [DWIDTH-1:0] rdB_data,
  input  logic              wr_req,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              wr_gnt,
  output logic              busy,
  output logic [AWIDTH-1:0] ram_addr0,
  output logic              ram_ce0,
  input  logic [DWIDTH-1:0] ram_q0,
  output logic [AWIDTH-1:0] ram_addr1,
  output logic              ram_ce1,
  output logic              ram_we1,
  output logic [DWIDTH-1:0] ram_d1,
  input  logic [DWIDTH-1:0] ram_q1
);

  if (MEM_SIZE < 1 || MEM_SIZE > (1 << AWIDTH)) begin : g_size_check
    $error("MEM_SIZE does not fit in AWIDTH address bits");
  end

  logic              w_sweep;
  logic              w_run;
  logic [AWIDTH-1:0] w_sweep_addr;

`ifdef LUT_ARB_INIT_EN
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic              r_state;
  logic [AWIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else if (r_state == ST_INIT) begin
      if (r_cnt == AWIDTH'(MEM_SIZE - 1)) begin
        r_state <= ST_RUN;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_sweep      = (r_state == ST_INIT) && !rst;
  assign w_run        = (r_state == ST_RUN) && !rst;
  assign w_sweep_addr = r_cnt;
  assign busy         = (r_state == ST_INIT);
`else
  assign w_sweep      = 1'b0;
  assign w_run        = !rst;
  assign w_sweep_addr = '0;
  assign busy         = 1'b0;
`endif

  logic r_rr;      // 0: reader A wins the next port0 contention
  logic r_a_vld;
  logic r_b_vld;
  logic r_b_p1;    // reader B's in-flight read was served by port1

  always_comb begin
    rdA_gnt   = 1'b0;
    rdB_gnt   = 1'b0;
    wr_gnt    = 1'b0;
    ram_ce0   = 1'b0;
    ram_addr0 = rdA_addr;
    ram_ce1   = 1'b0;
    ram_we1   = 1'b0;
    ram_addr1 = wr_addr;
    ram_d1    = w_sweep ? INIT_VAL : wr_data;
    if (w_sweep) begin
      ram_ce1   = 1'b1;
      ram_we1   = 1'b1;
      ram_addr1 = w_sweep_addr;
    end else if (w_run) begin
      if (wr_req) begin
        // Writer owns port1; readers share port0
        wr_gnt  = 1'b1;
        ram_ce1 = 1'b1;
        ram_we1 = 1'b1;
        if (rdA_req && (!rdB_req || !r_rr)) begin
          rdA_gnt   = 1'b1;
          ram_ce0   = 1'b1;
          ram_addr0 = rdA_addr;
        end else if (rdB_req) begin
          rdB_gnt   = 1'b1;
          ram_ce0   = 1'b1;
          ram_addr0 = rdB_addr;
        end
      end else begin
        if (rdA_req) begin
          rdA_gnt   = 1'b1;
          ram_ce0   = 1'b1;
          ram_addr0 = rdA_addr;
        end
        if (rdB_req) begin
          rdB_gnt   = 1'b1;
          ram_ce1   = 1'b1;
          ram_addr1 = rdB_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr    <= 1'b0;
      r_a_vld <= 1'b0;
      r_b_vld <= 1'b0;
      r_b_p1  <= 1'b0;
    end else begin
      r_a_vld <= rdA_gnt;
      r_b_vld <= rdB_gnt;
      r_b_p1  <= rdB_gnt && !wr_gnt;
      if (wr_gnt && rdA_req && rdB_req) begin
        r_rr <= ~r_rr;
      end
    end
  end

  assign rdA_vld  = r_a_vld;
  assign rdB_vld  = r_b_vld;
  assign rdA_data = ram_q0;
  assign rdB_data = r_b_p1 ? ram_q1 : ram_q0;

endmodule
